nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_if.sv | 28 ++
 rtl/nibble_serial_adder.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The master drives operands and accepts results; the slave is the adder.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial adder: one 4-bit lookahead slice per cycle, carry held between slices.
//   state | meaning
//   IDLE  | ready for an operand set, no result
//   RUN   | adding nibble idx, one per cycle
//   DONE  | result held until out_ready
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [3:0] a_nib, b_nib, g, p, nib_sum;
    logic [4:0] c;

    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        g    = a_nib & b_nib;
        p    = a_nib ^ b_nib;
        c[0] = carry_q;
        // Fully expanded lookahead so no carry ripples through the slice
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nib_sum = p ^ c[3:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) sum_d[4*i +: 4] = nib_sum;
                end
                carry_d = c[4];
                if (idx_q == IDX_LAST) begin
                    cout_d  = c[4];
                    ovf_d   = c[3] ^ c[4];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Ends on the first falling edge after the acceptance edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        @(negedge clk);
        chk("accept_in_ready", 64'(bus.in_ready), 64'd1);
        bus.a        = ta;
        bus.b        = tb_;
        bus.cin      = tc;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        chk("latency", 64'(cnt), 64'(NIBBLES));
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
        start_op(ta, tb_, tc);
        wait_done();
        chk({tag, "_sum"}, 64'(bus.sum), 64'(es));
        chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
        release_out();
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic [W:0]   ref_full;
        logic [W-1:0] ra, rb;
        logic         rc, ref_ovf;
        int           bp;

        n_chk = 0;
        n_bad = 0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;

        directed("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("sovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("ones",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        directed("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Hold DONE with backpressure while new operands are offered
        start_op(16'hA5A5, 16'h0F0F, 1'b1);
        wait_done();
        chk("hold_sum0", 64'(bus.sum), 64'hB4B5);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a        = 16'h1111 * 16'(i);
            bus.b        = 16'h0101;
            bus.cin      = ~i[0];
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_sum", 64'(bus.sum), 64'hB4B5);
            chk("hold_cout", 64'(bus.cout), 64'd0);
        end
        bus.in_valid = 1'b0;
        release_out();
        @(posedge clk);
        @(negedge clk);
        chk("no_queue_in_ready", 64'(bus.in_ready), 64'd1);

        // Reset in RUN at idx=2
        start_op(16'h1234, 16'h4321, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("partial_sum", 64'(bus.sum[7:0]), 64'h55);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_sum", 64'(bus.sum), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        directed("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (k % 50 == 0) begin
                ra = 16'hFFFF;
                rb = 16'(k);
            end
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            ref_ovf  = (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]);
            start_op(ra, rb, rc);
            wait_done();
            bp = $urandom_range(0, 3);
            for (int j = 0; j < bp; j++) begin
                @(posedge clk);
                @(negedge clk);
            end
            held_sum = bus.sum;
            chk("rnd_sum", 64'(held_sum), 64'(ref_full[W-1:0]));
            chk("rnd_cout", 64'(bus.cout), 64'(ref_full[W]));
            chk("rnd_ovf", 64'(bus.ovf), 64'(ref_ovf));
            release_out();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
